// File: rtl/mbv_result_collector.sv
// mbv_result_collector
//   Downstream stage of the matrix-by-vector engine. Each result word the
//   decoder presents on outsider_read_now is captured into a circular FIFO and
//   streamed out over a valid/ready handshake. Words are counted against the
//   expected row total; done rises once the whole result vector has left.
//
// Optional build macro:
//   COLLECTOR_ZERO_PAD_EN - when defined, lanes of the final word that lie
//   beyond total_rows are stored as zero. Undefined: stored as received.
//
// Ports:
//   clk, reset         clock (rising edge), asynchronous active-low reset
//   start              level enable; rise latches total_rows, low aborts to IDLE
//   total_rows         number of valid result elements expected
//   in_data            decoder result word, lane 0 in the MSB slice
//   outsider_read_now  one-cycle capture strobe for in_data
//   m_data/m_valid     FIFO head word and its valid
//   m_ready            consumer accept
//   m_last             head is the final expected word
//   full               FIFO holds DEPTH words
//   overflow           sticky: a strobe was dropped because the FIFO was full
//   done               all expected words received and drained
module mbv_result_collector #(
    parameter int element_width = 32,
    parameter int NI            = 8,
    parameter int DEPTH         = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [31:0]                 total_rows,
    input  logic [NI*element_width-1:0] in_data,
    input  logic                        outsider_read_now,
    output logic [NI*element_width-1:0] m_data,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic                        m_last,
    output logic                        full,
    output logic                        overflow,
    output logic                        done
);

    localparam int WW = NI * element_width;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DRAIN, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [WW-1:0]   mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic [31:0]     words_exp, rx_cnt, tx_cnt;
    logic [31:0]     words_calc;
    logic            overflow_q;
    logic            rx_done, accept, push, pop, drop;
    logic [WW-1:0]   pad_data;

    // ceil(total_rows / NI) in 32-bit unsigned arithmetic
    assign words_calc = (total_rows + 32'(NI - 1)) / 32'(NI);

    assign rx_done  = (rx_cnt == words_exp);
    assign m_valid  = (count != '0);
    assign full     = (count == FULL_CNT);
    assign pop      = m_valid & m_ready;
    // strobes only count while collecting and before the last expected word
    assign accept   = (state_q == S_COLLECT) && outsider_read_now && !rx_done;
    // a full FIFO can still take a word when the head leaves in the same cycle
    assign push     = accept && (!full || pop);
    assign drop     = accept && full && !pop;

    assign m_data   = m_valid ? mem[rd_ptr] : '0;
    assign m_last   = m_valid && (tx_cnt == words_exp - 32'd1);
    assign overflow = overflow_q;
    assign done     = (state_q == S_DONE);

`ifdef COLLECTOR_ZERO_PAD_EN
    logic [31:0] tot_q;
    logic [31:0] keep_lanes;
    logic        last_word;

    // number of meaningful lanes in the final word
    assign keep_lanes = tot_q - 32'(NI) * (words_exp - 32'd1);
    assign last_word  = (rx_cnt == words_exp - 32'd1);

    for (genvar l = 0; l < NI; l++) begin : g_pad
        assign pad_data[(NI-l)*element_width-1 -: element_width] =
            (last_word && (32'(l) >= keep_lanes)) ? '0
                : in_data[(NI-l)*element_width-1 -: element_width];
    end
`else
    assign pad_data = in_data;
`endif

    // next-state
    always_comb begin
        state_d = state_q;
        if (!start) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:    state_d = S_COLLECT;
                S_COLLECT: if (rx_done) state_d = S_DRAIN;
                S_DRAIN:   if (tx_cnt == words_exp) state_d = S_DONE;
                S_DONE:    state_d = S_DONE;
                default:   state_d = S_IDLE;
            endcase
        end
    end

    // storage has no reset; valid words are tracked by count/pointers
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= pad_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            words_exp  <= '0;
            rx_cnt     <= '0;
            tx_cnt     <= '0;
            overflow_q <= 1'b0;
`ifdef COLLECTOR_ZERO_PAD_EN
            tot_q      <= '0;
`endif
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE || !start) begin
                // idle or abort: discard buffered words and counters
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                count      <= '0;
                rx_cnt     <= '0;
                tx_cnt     <= '0;
                overflow_q <= 1'b0;
                if (state_q == S_IDLE && start) begin
                    words_exp <= words_calc;
`ifdef COLLECTOR_ZERO_PAD_EN
                    tot_q     <= total_rows;
`endif
                end
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                    rx_cnt <= rx_cnt + 32'd1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                    tx_cnt <= tx_cnt + 32'd1;
                end
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
                if (drop) overflow_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mbv_result_collector.sv
// Directed bench for mbv_result_collector (element_width=32, NI=8, DEPTH=16).
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_mbv_result_collector;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [31:0]  total_rows;
    logic [255:0] in_data;
    logic         outsider_read_now;
    logic [255:0] m_data;
    logic         m_valid;
    logic         m_ready;
    logic         m_last;
    logic         full;
    logic         overflow;
    logic         done;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mbv_result_collector #(.element_width(32), .NI(8), .DEPTH(16)) dut (
        .clk(clk), .reset(reset), .start(start), .total_rows(total_rows),
        .in_data(in_data), .outsider_read_now(outsider_read_now),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .full(full), .overflow(overflow), .done(done)
    );

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // word k: lane l carries k*8+l, lane 0 in the MSB slice
    function automatic logic [255:0] mkword(input int k);
        logic [255:0] w;
        w = '0;
        for (int l = 0; l < 8; l++) w[(7-l)*32 +: 32] = 32'(k * 8 + l);
        return w;
    endfunction

    task automatic strobe(input logic [255:0] w);
        in_data = w;
        outsider_read_now = 1'b1;
        tick();
        outsider_read_now = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [255:0] wb, wexp;
        int cyc;
        reset = 1'b0; start = 1'b0; total_rows = '0; in_data = '0;
        outsider_read_now = 1'b0; m_ready = 1'b0;
        #12;
        chk("rst_m_data", m_data, '0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_full", full, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_done", done, 0);
        reset = 1'b1;
        tick();

        // basic stream: 16 rows -> 2 words, strobes 3 cycles apart
        start = 1'b1; total_rows = 32'd16; m_ready = 1'b1;
        tick();
        strobe(mkword(1));
        chk("b_w1_valid", m_valid, 1);
        chk("b_w1_data", m_data, mkword(1));
        chk("b_w1_last", m_last, 0);
        tick();
        chk("b_pop1_valid", m_valid, 0);
        tick();
        strobe(mkword(2));
        chk("b_w2_data", m_data, mkword(2));
        chk("b_w2_last", m_last, 1);
        chk("b_w2_done", done, 0);
        tick();
        chk("b_pop2_valid", m_valid, 0);
        chk("b_pop2_done", done, 0);
        tick();
        chk("b_done", done, 1);
        start = 1'b0;
        tick();
        chk("b_idle_done", done, 0);

        // backpressure / overflow: 160 rows -> 20 words, consumer stalled
        start = 1'b1; total_rows = 32'd160; m_ready = 1'b0;
        tick();
        for (int i = 0; i < 15; i++) strobe(mkword(i));
        chk("o_full15", full, 0);
        strobe(mkword(15));
        chk("o_full16", full, 1);
        chk("o_ovf16", overflow, 0);
        strobe(mkword(16));
        chk("o_ovf17", overflow, 1);
        chk("o_rx17", dut.rx_cnt, 32'd16);
        chk("o_head", m_data, mkword(0));
        start = 1'b0;
        tick();
        chk("o_abort_ovf", overflow, 0);

        // push+pop while full
        start = 1'b1; total_rows = 32'd160;
        tick();
        for (int i = 0; i < 16; i++) strobe(mkword(i));
        m_ready = 1'b1;
        strobe(mkword(16));
        chk("pp_count", dut.count, 16);
        chk("pp_full", full, 1);
        chk("pp_ovf", overflow, 0);
        chk("pp_rx", dut.rx_cnt, 32'd17);
        for (int i = 1; i <= 16; i++) begin
            chk($sformatf("pp_order%0d", i), m_data, mkword(i));
            tick();
        end
        chk("pp_empty", m_valid, 0);
        start = 1'b0; m_ready = 1'b0;
        tick();

        // zero-pad: 10 rows -> 2 words, last word has 2 valid lanes
        start = 1'b1; total_rows = 32'd10;
        tick();
        strobe({8{32'hFFFF_FFFF}});
        wb = {32'h1111_1111, 32'h2222_2222, {6{32'hFFFF_FFFF}}};
        strobe(wb);
        chk("zp_first", m_data, {8{32'hFFFF_FFFF}});
        chk("zp_first_last", m_last, 0);
        m_ready = 1'b1;
        tick();
`ifdef COLLECTOR_ZERO_PAD_EN
        wexp = {32'h1111_1111, 32'h2222_2222, 192'h0};
`else
        wexp = wb;
`endif
        chk("zp_last_data", m_data, wexp);
        chk("zp_last_flag", m_last, 1);
        tick();
        tick();
        chk("zp_done", done, 1);
        start = 1'b0; m_ready = 1'b0;
        tick();

        // abort with 3 words buffered, then a normal 1-word run
        start = 1'b1; total_rows = 32'd80;
        tick();
        for (int i = 0; i < 3; i++) strobe(mkword(i + 40));
        chk("ab_count", dut.count, 3);
        start = 1'b0;
        tick();
        chk("ab_valid", m_valid, 0);
        chk("ab_count0", dut.count, 0);
        chk("ab_data", m_data, '0);
        start = 1'b1; total_rows = 32'd8;
        tick();
        strobe(mkword(7));
        chk("ab_re_data", m_data, mkword(7));
        chk("ab_re_last", m_last, 1);
        m_ready = 1'b1;
        tick();
        chk("ab_re_pop", m_valid, 0);
        tick();
        chk("ab_re_done", done, 1);
        start = 1'b0; m_ready = 1'b0;
        tick();

        // asynchronous reset in DRAIN
        start = 1'b1; total_rows = 32'd24;
        tick();
        for (int i = 0; i < 3; i++) strobe(mkword(i + 60));
        tick();
        chk("ar_pre_valid", m_valid, 1);
        chk("ar_pre_full", full, 0);
        #3 reset = 1'b0;
        #1;
        chk("ar_valid", m_valid, 0);
        chk("ar_data", m_data, '0);
        chk("ar_last", m_last, 0);
        chk("ar_done", done, 0);
        total_rows = 32'd0;
        #2 reset = 1'b1;
        cyc = 0;
        while (!done && cyc < 5) begin
            tick();
            cyc++;
        end
        chk("ar_done_seen", done, 1);
        chk("ar_done_cycles", 256'(cyc), 256'(3));
        chk("ar_no_traffic", m_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
